// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single shared memory port.
// One transaction in flight at a time, with fair tie-breaking and a wait-cycle timeout abort.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic        m0_mem_write,
    input  logic        m0_mem_valid,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,
    output logic        m0_mem_err,

    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic        m1_mem_write,
    input  logic        m1_mem_valid,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,
    output logic        m1_mem_err,

    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic        s_mem_write,
    output logic        s_mem_valid,
    input  logic [31:0] s_mem_rdata,
    input  logic        s_mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        owner;
    logic [7:0]  tmo_cnt;

    logic        grant;
    logic        grant_sel;
    logic        done_ok;
    logic        done_tmo;
    logic [31:0] resp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tie goes to whichever requester did not win the previous grant.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_sel  = 1'b0;
        done_ok    = 1'b0;
        done_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_mem_valid || m1_mem_valid) begin
                    grant      = 1'b1;
                    grant_sel  = (m0_mem_valid && m1_mem_valid) ? ~last_grant : m1_mem_valid;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (s_mem_ready) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (tmo_cnt == TIMEOUT_LAST) begin
                    done_tmo   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign resp_data = done_ok ? s_mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            tmo_cnt      <= 8'd0;
            s_mem_addr   <= 32'd0;
            s_mem_wdata  <= 32'd0;
            s_mem_write  <= 1'b0;
            s_mem_valid  <= 1'b0;
            m0_mem_ready <= 1'b0;
            m0_mem_err   <= 1'b0;
            m0_mem_rdata <= 32'd0;
            m1_mem_ready <= 1'b0;
            m1_mem_err   <= 1'b0;
            m1_mem_rdata <= 32'd0;
        end else begin
            // Completion flags are single-cycle pulses, so they fall back by default.
            m0_mem_ready <= 1'b0;
            m0_mem_err   <= 1'b0;
            m1_mem_ready <= 1'b0;
            m1_mem_err   <= 1'b0;

            if (grant) begin
                s_mem_addr  <= grant_sel ? m1_mem_addr  : m0_mem_addr;
                s_mem_wdata <= grant_sel ? m1_mem_wdata : m0_mem_wdata;
                s_mem_write <= grant_sel ? m1_mem_write : m0_mem_write;
                s_mem_valid <= 1'b1;
                owner       <= grant_sel;
                last_grant  <= grant_sel;
                tmo_cnt     <= 8'd0;
            end

            if (state == BUSY && !s_mem_ready) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end

            if (done_ok || done_tmo) begin
                s_mem_valid <= 1'b0;
                if (owner) begin
                    m1_mem_rdata <= resp_data;
                    m1_mem_ready <= 1'b1;
                    m1_mem_err   <= done_tmo;
                end else begin
                    m0_mem_rdata <= resp_data;
                    m0_mem_ready <= 1'b1;
                    m0_mem_err   <= done_tmo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random transactions,
// each predicted by a transaction-level model of grant order, wait/timeout outcome and held read data.
module tb_mem_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0_mem_addr = '0, m0_mem_wdata = '0, m1_mem_addr = '0, m1_mem_wdata = '0;
    logic        m0_mem_write = 1'b0, m0_mem_valid = 1'b0, m1_mem_write = 1'b0, m1_mem_valid = 1'b0;
    logic        m0_mem_ready, m0_mem_err, m1_mem_ready, m1_mem_err;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic        s_mem_write, s_mem_valid;
    logic [31:0] s_mem_rdata = '0;
    logic        s_mem_ready = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        model_last = 1'b1;
    logic [31:0] model_hold [2] = '{32'd0, 32'd0};

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_mem_addr(m0_mem_addr), .m0_mem_wdata(m0_mem_wdata), .m0_mem_write(m0_mem_write),
        .m0_mem_valid(m0_mem_valid), .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m0_mem_err(m0_mem_err),
        .m1_mem_addr(m1_mem_addr), .m1_mem_wdata(m1_mem_wdata), .m1_mem_write(m1_mem_write),
        .m1_mem_valid(m1_mem_valid), .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .m1_mem_err(m1_mem_err),
        .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata), .s_mem_write(s_mem_write),
        .s_mem_valid(s_mem_valid), .s_mem_rdata(s_mem_rdata), .s_mem_ready(s_mem_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_svalid"}, 32'(s_mem_valid), 32'd0);
        checkOutput({tag, "_m0ready"}, 32'(m0_mem_ready), 32'd0);
        checkOutput({tag, "_m1ready"}, 32'(m1_mem_ready), 32'd0);
        checkOutput({tag, "_m0rdata"}, m0_mem_rdata, model_hold[0]);
        checkOutput({tag, "_m1rdata"}, m1_mem_rdata, model_hold[1]);
    endtask

    // Called at a falling edge while the arbiter is idle; returns at the falling edge back in idle.
    task automatic applyStimulus(input string tag, input logic v0, input logic v1,
                                 input logic [31:0] a0, input logic [31:0] d0, input logic w0,
                                 input logic [31:0] a1, input logic [31:0] d1, input logic w1,
                                 input int delay, input logic [31:0] rd);
        logic        win;
        logic        ok;
        int          last;
        logic [31:0] exp_rd;
        m0_mem_addr = a0; m0_mem_wdata = d0; m0_mem_write = w0; m0_mem_valid = v0;
        m1_mem_addr = a1; m1_mem_wdata = d1; m1_mem_write = w1; m1_mem_valid = v1;
        win = (v0 && v1) ? ~model_last : v1;
        model_last = win;
        ok = (delay < TMO);
        last = ok ? delay : TMO - 1;
        exp_rd = ok ? rd : 32'd0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            checkOutput({tag, "_busy_svalid"}, 32'(s_mem_valid), 32'd1);
            checkOutput({tag, "_busy_addr"}, s_mem_addr, win ? a1 : a0);
            checkOutput({tag, "_busy_wdata"}, s_mem_wdata, win ? d1 : d0);
            checkOutput({tag, "_busy_write"}, 32'(s_mem_write), 32'(win ? w1 : w0));
            checkOutput({tag, "_busy_readies"}, 32'({m1_mem_ready, m0_mem_ready}), 32'd0);
            s_mem_ready = (c == delay);
            s_mem_rdata = (c == delay) ? rd : $urandom;
            m0_mem_addr = $urandom; m0_mem_wdata = $urandom; m0_mem_write = 1'($urandom);
            m1_mem_addr = $urandom; m1_mem_wdata = $urandom; m1_mem_write = 1'($urandom);
        end
        @(negedge clk);
        checkOutput({tag, "_resp_svalid"}, 32'(s_mem_valid), 32'd0);
        checkOutput({tag, "_resp_win_ready"}, 32'(win ? m1_mem_ready : m0_mem_ready), 32'd1);
        checkOutput({tag, "_resp_win_err"}, 32'(win ? m1_mem_err : m0_mem_err), 32'(!ok));
        checkOutput({tag, "_resp_win_rdata"}, win ? m1_mem_rdata : m0_mem_rdata, exp_rd);
        checkOutput({tag, "_resp_lose_ready"}, 32'(win ? m0_mem_ready : m1_mem_ready), 32'd0);
        checkOutput({tag, "_resp_lose_err"}, 32'(win ? m0_mem_err : m1_mem_err), 32'd0);
        checkOutput({tag, "_resp_lose_rdata"}, win ? m0_mem_rdata : m1_mem_rdata, model_hold[!win]);
        model_hold[win] = exp_rd;
        s_mem_ready = 1'b0;
        m0_mem_valid = 1'b0;
        m1_mem_valid = 1'b0;
        @(negedge clk);
        checkQuiet({tag, "_idle"});
        checkOutput({tag, "_idle_err"}, 32'({m1_mem_err, m0_mem_err}), 32'd0);
    endtask

    initial begin
        $display("[TB] mem_arbiter bench start, TIMEOUT=%0d", TMO);
        repeat (2) @(negedge clk);
        checkQuiet("reset");
        checkOutput("reset_err", 32'({m1_mem_err, m0_mem_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie-break alternation starting from reset.
        applyStimulus("tie_first", 1'b1, 1'b1, 32'h100, 32'h11, 1'b1, 32'h200, 32'h22, 1'b0, 0, 32'hC0DE0000);
        applyStimulus("tie_second", 1'b1, 1'b1, 32'h104, 32'h33, 1'b0, 32'h204, 32'h44, 1'b1, 1, 32'hC0DE0001);
        applyStimulus("tie_third", 1'b1, 1'b1, 32'h108, 32'h55, 1'b0, 32'h208, 32'h66, 1'b0, 2, 32'hC0DE0002);

        applyStimulus("single_write", 1'b1, 1'b0, 32'h0, 32'hABCD1234, 1'b1, 32'h0, 32'h0, 1'b0, 0, 32'h0);
        applyStimulus("m1_read", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h10, 32'h0, 1'b0, 3, 32'h5A5A0001);
        applyStimulus("timeout", 1'b1, 1'b0, 32'h40, 32'h77, 1'b0, 32'h0, 32'h0, 1'b0, 1000, 32'hFFFFFFFF);
        applyStimulus("coincident", 1'b1, 1'b0, 32'h44, 32'h88, 1'b0, 32'h0, 32'h0, 1'b0, TMO - 1, 32'h13579BDF);

        // Stray completion strobes while idle must not disturb anything.
        s_mem_ready = 1'b1;
        s_mem_rdata = 32'hDEADBEEF;
        repeat (3) begin
            @(negedge clk);
            checkQuiet("stray_ready");
        end
        s_mem_ready = 1'b0;

        // Reset pulse in the middle of a wait: the transaction is dropped silently.
        m0_mem_addr = 32'h80; m0_mem_wdata = 32'h99; m0_mem_write = 1'b1; m0_mem_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_busy_svalid", 32'(s_mem_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m0_mem_valid = 1'b0;
        model_last = 1'b1;
        model_hold[0] = 32'd0;
        model_hold[1] = 32'd0;
        checkQuiet("rst_mid_busy");
        @(negedge clk);
        checkQuiet("rst_mid_busy_after");
        applyStimulus("tie_after_rst", 1'b1, 1'b1, 32'h300, 32'hA1, 1'b0, 32'h400, 32'hB2, 1'b1, 0, 32'h0BADF00D);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] vv;
            int         dly;
            vv  = 2'($urandom_range(1, 3));
            dly = ($urandom_range(0, 3) == 0) ? (TMO - 2 + int'($urandom_range(0, 3))) : int'($urandom_range(0, 6));
            applyStimulus("random", vv[0], vv[1], $urandom, $urandom, 1'($urandom),
                          $urandom, $urandom, 1'($urandom), dly, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning maximum cycles s_mem_valid is held without s_mem_ready before abort (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have, for each requester i in {0,1}, ports mi_mem_addr input 32, mi_mem_wdata input 32, mi_mem_write input 1, mi_mem_valid input 1 (request).
REQ-005 SHALL have, for each i, ports mi_mem_ready output 1 (one-cycle completion pulse), mi_mem_rdata output 32 (read data), mi_mem_err output 1 (timeout flag, valid with ready).
REQ-006 SHALL have ports s_mem_addr output 32, s_mem_wdata output 32, s_mem_write output 1, s_mem_valid output 1 (shared memory request).
REQ-007 SHALL have ports s_mem_rdata input 32, s_mem_ready input 1 (shared memory completion).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, RESP; exactly one transaction outstanding at any time.
REQ-009 SHALL, in IDLE with no mi_mem_valid high, remain in IDLE.
REQ-010 SHALL, in IDLE with exactly one mi_mem_valid high, grant that requester at the next edge.
REQ-011 SHALL, in IDLE with both valid high, grant the requester not recorded in last_grant; last_grant updates to the winner on every grant.
REQ-012 SHALL, on grant, capture the winner's addr/wdata/write into s_mem_addr/s_mem_wdata/s_mem_write, set s_mem_valid=1, record owner, clear timeout counter, enter BUSY.
REQ-013 SHALL hold all s_mem_* outputs stable throughout BUSY; requester input changes during BUSY are ignored.
REQ-014 SHALL, in BUSY with s_mem_ready=1, at the next edge set s_mem_valid=0, register s_mem_rdata into owner's mi_mem_rdata, mi_mem_ready=1, mi_mem_err=0, enter RESP.
REQ-015 SHALL, in BUSY with s_mem_ready=0, increment 8-bit timeout counter each cycle; when counter equals TIMEOUT-1 and s_mem_ready=0, at the next edge set s_mem_valid=0, owner mi_mem_rdata=0, mi_mem_ready=1, mi_mem_err=1, enter RESP.
REQ-016 SHALL give s_mem_ready priority over timeout when both occur in the same cycle (normal completion, err=0).
REQ-017 SHALL, in RESP, hold mi_mem_ready/mi_mem_err high for exactly that one cycle, then clear them and return to IDLE; no grant is made from RESP.
REQ-018 SHALL hold mi_mem_rdata of each requester until its next completion.
REQ-019 SHALL never assert ready/err to the non-owner requester.
REQ-020 SHALL ignore s_mem_ready in IDLE and RESP.
REQ-021 SHALL achieve minimum latency: request in IDLE at cycle N, s_mem_valid high cycle N+1, ready sampled cycle N+1 gives mi_mem_ready at cycle N+2, IDLE at N+3.
REQ-022 SHALL require requesters to deassert mi_mem_valid the cycle after mi_mem_ready; a still-high valid in IDLE is treated as a new request.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, set state=IDLE, last_grant=1 (requester 0 wins first tie), timeout counter=0, all outputs 0.
REQ-024 SHALL, on reset mid-BUSY or mid-RESP, abandon the transaction with no ready pulse issued, s_mem_valid=0 after that edge.

Verification
REQ-025 Single request: m0 write addr 0x00000000 data 0xABCD1234, s_mem_ready high first BUSY cycle -> s_mem_* matches at N+1, m0_mem_ready pulse at N+2, err=0.
REQ-026 Tie: both valid same cycle after reset -> m0 served first; both re-request -> m1 served next; alternation continues.
REQ-027 Read: m1 read addr 0x10, s_mem_rdata=0x5A5A0001 with ready after 3 wait cycles -> m1_mem_rdata=0x5A5A0001, m1 ready one cycle, m0 outputs unchanged.
REQ-028 Timeout: TIMEOUT=16, s_mem_ready held 0 -> s_mem_valid high exactly 16 cycles, then m0 ready=1, err=1, rdata=0; ready and timeout coincident -> err=0.
REQ-029 Reset mid-BUSY: rst_n low one cycle during wait -> no ready pulse, s_mem_valid=0, next tie grants m0.
REQ-030 Stray s_mem_ready=1 in IDLE -> no output change.
